// File: rtl/demux4_stream_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : demux4_stream_pkg
//  Purpose  : Shared constants and types for the 1-to-4 stream demultiplexer.
//             NUM_CH = number of output channels, SEL_W = select width,
//             CNT_W = width of each optional per-channel accept counter.
//  Revision : 1.0 - initial release
// ============================================================================
package demux4_stream_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;
  localparam int CNT_W  = 16;

  typedef logic [SEL_W-1:0] ch_sel_t;

endpackage : demux4_stream_pkg
`default_nettype wire

// File: rtl/demux4_stream_if.sv
`default_nettype none
// ============================================================================
//  Module   : demux4_stream_if
//  Purpose  : Bundles the producer-side stream and the four consumer-side
//             lanes of demux4_stream.
//  Signals  : in_valid/in_ready/in_data/in_sel  - shared input stream
//             out_valid[i]/out_ready[i]         - per-channel handshake
//             out_data[i*WIDTH +: WIDTH]        - per-channel word
//  Modports : master - producer/consumer environment
//             slave  - the demultiplexer
//  Revision : 1.0 - initial release
// ============================================================================
interface demux4_stream_if
  import demux4_stream_pkg::*;
#(
  parameter int WIDTH = 8
) ();

  logic                    in_valid;
  logic                    in_ready;
  logic [WIDTH-1:0]        in_data;
  ch_sel_t                 in_sel;
  logic [NUM_CH-1:0]       out_valid;
  logic [NUM_CH-1:0]       out_ready;
  logic [NUM_CH*WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, in_sel, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_sel, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface : demux4_stream_if
`default_nettype wire

// File: rtl/demux4_stream_slot.sv
`default_nettype none
// ============================================================================
//  Module   : demux4_slot
//  Purpose  : One-entry valid/ready holding register for one output channel.
//  Ports    : clk, rst   - clock, asynchronous active-high reset
//             load       - write ld_data into the slot this edge
//             ld_data    - word to store
//             out_ready  - consumer ready for this channel
//             free       - slot can take a word this cycle
//             valid      - slot holds a word
//             data       - held word (keeps last value after drain)
//  Revision : 1.0 - initial release
// ============================================================================
module demux4_slot #(
  parameter int WIDTH = 8
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             load,
  input  wire logic [WIDTH-1:0] ld_data,
  input  wire logic             out_ready,
  output logic                  free,
  output logic                  valid,
  output logic [WIDTH-1:0]      data
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  // Draining and refilling in the same cycle keeps one word/cycle throughput.
  assign free  = ~r_valid | out_ready;
  assign valid = r_valid;
  assign data  = r_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (load) begin
      r_valid <= 1'b1;
      r_data  <= ld_data;
    end else if (out_ready) begin
      // Data deliberately left untouched so the slice holds its last value.
      r_valid <= 1'b0;
    end
  end

endmodule : demux4_slot
`default_nettype wire

// File: rtl/demux4_stream.sv
`default_nettype none
// ============================================================================
//  Module   : demux4_stream
//  Purpose  : 1-to-4 registered stream demultiplexer. Each accepted word is
//             steered by in_sel into one of four independent one-entry
//             channel slots; back-pressure is isolated per channel.
//  Ports    : clk      - clock, rising edge
//             rst      - asynchronous active-high reset
//             bus      - demux4_stream_if.slave (input stream + 4 lanes)
//             acc_cnt  - per-channel accept counters, 16 bits each
//                        (present only with DEMUX4_STREAM_CNT_EN defined)
//  Options  : DEMUX4_STREAM_CNT_EN - enables the acc_cnt counters/port
//  Revision : 1.0 - initial release
// ============================================================================
module demux4_stream
  import demux4_stream_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  wire logic               clk,
  input  wire logic               rst,
`ifdef DEMUX4_STREAM_CNT_EN
  demux4_stream_if.slave          bus,
  output logic [NUM_CH*CNT_W-1:0] acc_cnt
`else
  demux4_stream_if.slave          bus
`endif
);

  logic [NUM_CH-1:0]       w_free;
  logic [NUM_CH-1:0]       w_valid;
  logic [NUM_CH-1:0]       w_load;
  logic [NUM_CH*WIDTH-1:0] w_data;
  logic                    w_in_ready;

  // Ready depends only on the targeted slot, never on in_valid, so a stalled
  // channel blocks only words addressed to it.
  assign w_in_ready    = ~rst & w_free[bus.in_sel];
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_valid;
  assign bus.out_data  = w_data;

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
      assign w_load[i] = bus.in_valid & w_in_ready & (bus.in_sel == ch_sel_t'(i));

      demux4_slot #(
        .WIDTH (WIDTH)
      ) u_slot (
        .clk       (clk),
        .rst       (rst),
        .load      (w_load[i]),
        .ld_data   (bus.in_data),
        .out_ready (bus.out_ready[i]),
        .free      (w_free[i]),
        .valid     (w_valid[i]),
        .data      (w_data[i*WIDTH +: WIDTH])
      );
    end
  endgenerate

`ifdef DEMUX4_STREAM_CNT_EN
  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_cnt
      logic [CNT_W-1:0] r_cnt;

      // Free-running wrap from all-ones back to zero.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_cnt <= '0;
        end else if (w_load[i]) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end

      assign acc_cnt[i*CNT_W +: CNT_W] = r_cnt;
    end
  endgenerate
`endif

endmodule : demux4_stream
`default_nettype wire

// File: tb/tb_demux4_stream.sv
`default_nettype none
// ============================================================================
//  Module   : tb_demux4_stream
//  Purpose  : Self-checking bench for demux4_stream. Accepted words are pushed
//             into per-channel expected queues; a separate monitor compares
//             every presented word against the queue heads.
//  Options  : DEMUX4_STREAM_CNT_EN - also exercises the accept counters
//  Revision : 1.0 - initial release
// ============================================================================
module tb_demux4_stream;
  import demux4_stream_pkg::*;

  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  logic [WIDTH-1:0] q [NUM_CH][$];

  demux4_stream_if #(.WIDTH(WIDTH)) bus ();

`ifdef DEMUX4_STREAM_CNT_EN
  logic [NUM_CH*CNT_W-1:0] acc_cnt;
  demux4_stream #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus), .acc_cnt(acc_cnt));
`else
  demux4_stream #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change on the falling edge; the monitor looks at +1, the driver
  // checks in_ready and records accepts at +2, well before the rising edge.
  task automatic step(input logic v, input int sel, input logic [WIDTH-1:0] d,
                      input logic [NUM_CH-1:0] rdy);
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_sel    = ch_sel_t'(sel);
    bus.in_data   = d;
    bus.out_ready = rdy;
    #2;
    if (!rst) begin
      // Model holds at most one word per channel after draining this cycle.
      chk("in_ready", {63'd0, bus.in_ready}, {63'd0, q[sel].size() == 0});
      if (v && bus.in_ready) q[sel].push_back(d);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < NUM_CH; i++) q[i].delete();
  endtask

  // Monitor: output presence must equal model occupancy, data must equal the
  // queue head (also proves stability while stalled), drains pop the head.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        clear_model();
      end else begin
        for (int i = 0; i < NUM_CH; i++) begin
          chk($sformatf("out_valid[%0d]", i), {63'd0, bus.out_valid[i]},
              {63'd0, q[i].size() != 0});
          if (q[i].size() != 0) begin
            chk($sformatf("out_data[%0d]", i), {56'd0, bus.out_data[i*WIDTH +: WIDTH]},
                {56'd0, q[i][0]});
            if (bus.out_ready[i]) void'(q[i].pop_front());
          end
        end
      end
    end
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_sel    = '0;
    bus.in_data   = '0;
    bus.out_ready = '0;

    // Power-up reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {60'd0, bus.out_valid}, 64'd0);
    chk("rst_out_data", {32'd0, bus.out_data}, 64'd0);
    chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single route to channel c
    step(1'b1, 2, 8'hA5, 4'b1111);
    step(1'b0, 0, 8'h00, 4'b1111);
    chk("route_valid", {60'd0, bus.out_valid}, 64'h4);
    chk("route_data", {56'd0, bus.out_data[2*WIDTH +: WIDTH]}, 64'hA5);
    step(1'b0, 0, 8'h00, 4'b1111);
    chk("route_valid_drop", {60'd0, bus.out_valid}, 64'h0);

    // Back-pressure isolation on channel b
    step(1'b1, 1, 8'h11, 4'b1101);
    step(1'b1, 1, 8'h22, 4'b1101);
    chk("bp_stall", {63'd0, bus.in_ready}, 64'd0);
    step(1'b1, 3, 8'h33, 4'b1101);
    chk("bp_other_ch", {63'd0, bus.in_ready}, 64'd1);
    chk("bp_hold_data", {56'd0, bus.out_data[1*WIDTH +: WIDTH]}, 64'h11);
    step(1'b1, 1, 8'h22, 4'b1111);
    chk("bp_release", {63'd0, bus.in_ready}, 64'd1);
    step(1'b0, 0, 8'h00, 4'b1111);
    chk("bp_second_word", {56'd0, bus.out_data[1*WIDTH +: WIDTH]}, 64'h22);
    repeat (2) step(1'b0, 0, 8'h00, 4'b1111);

    // Throughput: back-to-back words into channel a
    for (int n = 0; n < 100; n++) step(1'b1, 0, WIDTH'($urandom), 4'b1111);
    repeat (2) step(1'b0, 0, 8'h00, 4'b1111);

    // Asynchronous reset while channel c holds a word
    step(1'b1, 2, 8'h5A, 4'b0000);
    step(1'b0, 0, 8'h00, 4'b0000);
    chk("hold_before_rst", {60'd0, bus.out_valid}, 64'h4);
    #1 rst = 1'b1;
    #1;
    chk("async_out_valid", {60'd0, bus.out_valid}, 64'd0);
    chk("async_out_data", {32'd0, bus.out_data}, 64'd0);
    chk("async_in_ready", {63'd0, bus.in_ready}, 64'd0);
    clear_model();
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 2, 8'h00, 4'b0000);
    chk("post_rst_ready", {63'd0, bus.in_ready}, 64'd1);

    // Randomized traffic with random per-lane back-pressure
    for (int n = 0; n < 10000; n++) begin
      step(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)),
           WIDTH'($urandom), NUM_CH'($urandom));
    end

    // Flush: every accepted word must have been delivered
    repeat (3) step(1'b0, 0, 8'h00, 4'b1111);
    for (int i = 0; i < NUM_CH; i++)
      chk($sformatf("flush_empty[%0d]", i), 64'(q[i].size()), 64'd0);

`ifdef DEMUX4_STREAM_CNT_EN
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("cnt_reset", acc_cnt, 64'd0);
    for (int n = 0; n < 65537; n++) step(1'b1, 3, WIDTH'(n), 4'b1111);
    step(1'b0, 0, 8'h00, 4'b1111);
    chk("cnt_wrap", acc_cnt, 64'h0001_0000_0000_0000);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_demux4_stream
`default_nettype wire
